led_pattern_decoder: RTL and testbench

Monitor/decoder for the 8-LED pattern generators: it watches an 8-bit LED bus, one sample per pattern step, and identifies which of the eight shift/fill patterns is running. It also flags wrap-around, pause and pattern violations. It sits beside a generator instance as a self-checking observer, or downstream of a captured LED bus on the board.

---
 rtl/led_pattern_pkg.sv | 31 +++
 rtl/led_step_predict.sv | 36 +++
 rtl/led_pattern_decoder.sv | 99 +++++++++
 tb/tb_led_pattern_decoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: pattern codes, wrap seeds and FSM encoding shared by the LED pattern decoder.
package led_pattern_pkg;
    localparam logic [3:0] PAT_NONE     = 4'd0;
    localparam logic [3:0] PAT_DICH_TSP = 4'd1;
    localparam logic [3:0] PAT_DICH_PST = 4'd2;
    localparam logic [3:0] PAT_DAN_TSP  = 4'd3;
    localparam logic [3:0] PAT_DAN_PST  = 4'd4;
    localparam logic [3:0] PAT_DICH_TRN = 4'd5;
    localparam logic [3:0] PAT_DICH_NVT = 4'd6;
    localparam logic [3:0] PAT_DAN_TRN  = 4'd7;
    localparam logic [3:0] PAT_DAN_NVT  = 4'd8;

    localparam logic [7:0] SEED_80 = 8'h80;
    localparam logic [7:0] SEED_01 = 8'h01;
    localparam logic [7:0] SEED_18 = 8'h18;
    localparam logic [7:0] SEED_81 = 8'h81;

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    function automatic logic is_onehot(input logic [8:1] m);
        return (m != 8'd0) && ((m & (m - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [3:0] onehot_code(input logic [8:1] m);
        logic [3:0] code;
        code = PAT_NONE;
        for (int k = 1; k <= 8; k++)
            if (m[k]) code = 4'(k);
        return code;
    endfunction
endpackage

// File: rtl/led_step_predict.sv
// led_step_predict: predicts the next LED step of all eight patterns and compares against the current sample.
module led_step_predict
    import led_pattern_pkg::*;
(
    input  logic [7:0] prev,
    input  logic [7:0] cur,
    output logic [8:1] match,
    output logic [8:1] is_wrap
);
    logic [3:0] hi;
    logic [3:0] lo;
    logic       zero;
    logic       full;
    logic [7:0] p [1:8];

    assign hi   = prev[7:4];
    assign lo   = prev[3:0];
    assign zero = prev == 8'h00;
    assign full = prev == 8'hFF;

    assign p[1] = zero ? SEED_80 : prev >> 1;
    assign p[2] = zero ? SEED_01 : prev << 1;
    assign p[3] = full ? 8'h00 : (prev >> 1) | SEED_80;
    assign p[4] = full ? 8'h00 : (prev << 1) | SEED_01;
    assign p[5] = zero ? SEED_18 : {hi << 1, lo >> 1};
    assign p[6] = zero ? SEED_81 : {hi >> 1, lo << 1};
    assign p[7] = full ? 8'h00 : {hi << 1, lo >> 1} | SEED_18;
    assign p[8] = full ? 8'h00 : {hi >> 1, lo << 1} | SEED_81;

    // Empty-seeded patterns wrap from 00, fill patterns wrap from FF.
    assign is_wrap = {full, full, zero, zero, full, full, zero, zero};

    for (genvar k = 1; k <= 8; k++) begin : g_match
        assign match[k] = cur == p[k];
    end
endmodule

// File: rtl/led_pattern_decoder.sv
// led_pattern_decoder: observes an 8-bit LED bus and locks onto whichever shift/fill pattern is running.
module led_pattern_decoder
    import led_pattern_pkg::*;
#(
    parameter int LOCK_COUNT  = 3,
    parameter int STALL_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_valid,
    input  logic [7:0] led_in,
    output logic [3:0] pattern,
    output logic       locked,
    output logic       paused,
    output logic       wrap_pulse,
    output logic       error
);
    localparam int CW = $clog2(LOCK_COUNT + 1);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(LOCK_COUNT);
    localparam logic [SW-1:0] STALL_MAX = SW'(STALL_LIMIT);

    state_t        state;
    logic [7:0]    prev;
    logic [8:1]    mask;
    logic [CW-1:0] cnt;
    logic [SW-1:0] stall_cnt;
    logic [8:1]    match;
    logic [8:1]    is_wrap;
    logic [8:1]    m;
    logic [CW-1:0] cnt_next;
    logic [SW-1:0] stall_next;
    logic          changed;

    led_step_predict u_predict (
        .prev    (prev),
        .cur     (led_in),
        .match   (match),
        .is_wrap (is_wrap)
    );

    assign changed    = led_in != prev;
    assign m          = mask & match;
    assign cnt_next   = (m == 8'd0) ? CW'(match != 8'd0) : (cnt == CNT_MAX ? cnt : cnt + CW'(1));
    assign stall_next = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + SW'(1);

    // While locked, mask holds the one-hot of the locked code.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev       <= 8'h00;
            mask       <= '1;
            cnt        <= '0;
            stall_cnt  <= '0;
            pattern    <= PAT_NONE;
            locked     <= 1'b0;
            paused     <= 1'b0;
            wrap_pulse <= 1'b0;
            error      <= 1'b0;
        end else begin
            wrap_pulse <= 1'b0;
            error      <= 1'b0;
            if (sample_valid) begin
                prev <= led_in;
                if (state == IDLE) begin
                    state <= TRACK;
                    mask  <= '1;
                    cnt   <= '0;
                end else if (!changed) begin
                    stall_cnt <= stall_next;
                    paused    <= stall_next == STALL_MAX;
                end else begin
                    stall_cnt <= '0;
                    paused    <= 1'b0;
                    if (state == LOCKED) begin
                        if (|(mask & match)) begin
                            wrap_pulse <= |(mask & match & is_wrap);
                        end else begin
                            error   <= 1'b1;
                            pattern <= PAT_NONE;
                            locked  <= 1'b0;
                            state   <= TRACK;
                            mask    <= match;
                            cnt     <= CW'(match != 8'd0);
                        end
                    end else begin
                        mask <= (m == 8'd0) ? match : m;
                        cnt  <= cnt_next;
                        if (is_onehot(m) && cnt_next >= CNT_MAX) begin
                            state   <= LOCKED;
                            pattern <= onehot_code(m);
                            locked  <= 1'b1;
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_decoder.sv
// tb_led_pattern_decoder: directed vector table, hand sequences and a randomized run against a behavioural model.
module tb_led_pattern_decoder;
    import led_pattern_pkg::*;

    localparam int LOCK  = 3;
    localparam int STALL = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_valid = 1'b0;
    logic [7:0] led_in = 8'h00;
    logic [3:0] pattern;
    logic       locked, paused, wrap_pulse, error;

    int checks = 0;
    int errors = 0;

    led_pattern_decoder #(.LOCK_COUNT(LOCK), .STALL_LIMIT(STALL)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .led_in       (led_in),
        .pattern      (pattern),
        .locked       (locked),
        .paused       (paused),
        .wrap_pulse   (wrap_pulse),
        .error        (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        bit         v;
        logic [7:0] led;
        logic [3:0] pat;
        bit         lk, ps, wr, er;
    } vec_t;

    vec_t vt[$];

    task automatic add(input bit r, input bit v, input logic [7:0] d, input logic [3:0] pat,
                       input bit lk, input bit ps, input bit wr, input bit er);
        vec_t e;
        e.rst = r; e.v = v; e.led = d; e.pat = pat; e.lk = lk; e.ps = ps; e.wr = wr; e.er = er;
        vt.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [3:0] pat, input bit lk, input bit ps,
                             input bit wr, input bit er);
        check({tag, ".pattern"}, {4'h0, pattern}, {4'h0, pat});
        check({tag, ".locked"}, {7'h0, locked}, {7'h0, lk});
        check({tag, ".paused"}, {7'h0, paused}, {7'h0, ps});
        check({tag, ".wrap_pulse"}, {7'h0, wrap_pulse}, {7'h0, wr});
        check({tag, ".error"}, {7'h0, error}, {7'h0, er});
    endtask

    task automatic apply(input bit r, input bit v, input logic [7:0] d);
        reset = r;
        sample_valid = v;
        led_in = d;
        @(posedge clk);
        #1;
    endtask

    // Next step of each pattern, computed arithmetically from the pattern definitions.
    function automatic int nxt(input int code, input int p);
        int hi, lo;
        hi = p / 16;
        lo = p % 16;
        case (code)
            1: return p == 0 ? 128 : p / 2;
            2: return p == 0 ? 1 : (p * 2) % 256;
            3: return p == 255 ? 0 : p / 2 + 128;
            4: return p == 255 ? 0 : (p * 2) % 256 + 1;
            5: return p == 0 ? 24 : ((hi * 2) % 16) * 16 + lo / 2;
            6: return p == 0 ? 129 : (hi / 2) * 16 + (lo * 2) % 16;
            7: return p == 255 ? 0 : ((((hi * 2) % 16) * 16 + lo / 2) | 24);
            8: return p == 255 ? 0 : (((hi / 2) * 16 + (lo * 2) % 16) | 129);
            default: return -1;
        endcase
    endfunction

    bit m_started, m_lk, m_ps, m_wr, m_er;
    int m_pat, m_run, m_still, m_prev;
    bit m_cand [1:8];

    task automatic model_step(input bit r, input bit v, input int d);
        bit hits [1:8];
        bit both [1:8];
        int n, last;
        bit any;
        m_wr = 0;
        m_er = 0;
        if (r) begin
            m_started = 0; m_lk = 0; m_ps = 0; m_pat = 0; m_run = 0; m_still = 0;
            for (int k = 1; k <= 8; k++) m_cand[k] = 1;
        end else if (v) begin
            if (!m_started) begin
                m_started = 1;
                m_run = 0;
                for (int k = 1; k <= 8; k++) m_cand[k] = 1;
            end else if (d == m_prev) begin
                if (m_still < STALL) m_still++;
                m_ps = m_still == STALL;
            end else begin
                m_still = 0;
                m_ps = 0;
                any = 0;
                for (int k = 1; k <= 8; k++) begin
                    hits[k] = nxt(k, m_prev) == d;
                    any |= hits[k];
                end
                if (m_lk) begin
                    if (hits[m_pat]) m_wr = (m_pat inside {1, 2, 5, 6}) ? (m_prev == 0) : (m_prev == 255);
                    else begin
                        m_er = 1; m_lk = 0; m_pat = 0; m_run = any ? 1 : 0;
                        for (int k = 1; k <= 8; k++) m_cand[k] = hits[k];
                    end
                end else begin
                    n = 0;
                    last = 0;
                    for (int k = 1; k <= 8; k++) begin
                        both[k] = m_cand[k] & hits[k];
                        if (both[k]) begin n++; last = k; end
                    end
                    if (n == 0) begin
                        m_run = any ? 1 : 0;
                        for (int k = 1; k <= 8; k++) m_cand[k] = hits[k];
                    end else begin
                        m_run = m_run < LOCK ? m_run + 1 : LOCK;
                        for (int k = 1; k <= 8; k++) m_cand[k] = both[k];
                    end
                    if (n == 1 && m_run >= LOCK) begin m_lk = 1; m_pat = last; end
                end
            end
            m_prev = d;
        end
    endtask

    initial begin
        // Fill-TSP lock, idle toggling, pause, resume, violation.
        add(1, 0, 8'h00, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0);
        add(0, 1, 8'h80, 0, 0, 0, 0, 0);
        add(0, 1, 8'hC0, 0, 0, 0, 0, 0);
        add(0, 1, 8'hE0, 3, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 8'($urandom), 3, 1, 0, 0, 0);
        for (int i = 0; i < 14; i++) add(0, 1, 8'hE0, 3, 1, 0, 0, 0);
        add(0, 1, 8'hE0, 3, 1, 1, 0, 0);
        add(0, 1, 8'hF0, 3, 1, 0, 0, 0);
        add(0, 1, 8'h55, 0, 0, 0, 0, 1);
        add(0, 0, 8'h55, 0, 0, 0, 0, 0);
        // Fill-NVT lock with a wrap, then reset mid-lock.
        add(1, 0, 8'h00, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0);
        add(0, 1, 8'h81, 0, 0, 0, 0, 0);
        add(0, 1, 8'hC3, 0, 0, 0, 0, 0);
        add(0, 1, 8'hE7, 8, 1, 0, 0, 0);
        add(0, 1, 8'hFF, 8, 1, 0, 0, 0);
        add(0, 1, 8'h00, 8, 1, 0, 1, 0);
        add(0, 1, 8'h81, 8, 1, 0, 0, 0);
        add(1, 1, 8'h55, 0, 0, 0, 0, 0);
        add(0, 1, 8'hFF, 0, 0, 0, 0, 0);
        add(0, 1, 8'h00, 0, 0, 0, 0, 0);

        foreach (vt[i]) begin
            apply(vt[i].rst, vt[i].v, vt[i].led);
            check_out($sformatf("vec%0d", i), vt[i].pat, vt[i].lk, vt[i].ps, vt[i].wr, vt[i].er);
        end

        // Candidate narrowing and return to tracking after a violation.
        apply(1, 0, 8'h00);
        apply(0, 1, 8'h00);
        apply(0, 1, 8'h80);
        check("mask_after_80", dut.mask, 8'h05);
        apply(0, 1, 8'hC0);
        check("mask_after_C0", dut.mask, 8'h04);
        apply(0, 1, 8'hE0);
        check("state_locked", {6'h0, dut.state}, {6'h0, LOCKED});
        apply(0, 1, 8'h55);
        check("state_after_error", {6'h0, dut.state}, {6'h0, TRACK});

        // Randomized run: generator-like stimulus with glitches, holds, gaps and resets.
        begin
            int gcode, gprev, hold_left, sel, d;
            bit rs, v;
            gcode = 1;
            gprev = 0;
            hold_left = 0;
            model_step(1, 0, 0);
            apply(1, 0, 8'h00);
            for (int i = 0; i < 3000; i++) begin
                rs = $urandom_range(0, 999) < 4;
                v = $urandom_range(0, 7) != 0;
                if ($urandom_range(0, 99) < 2) gcode = $urandom_range(1, 8);
                if (hold_left == 0 && $urandom_range(0, 99) < 2) hold_left = $urandom_range(14, 20);
                sel = $urandom_range(0, 99);
                if (hold_left > 0) d = gprev;
                else if (sel < 4) d = $urandom_range(0, 255);
                else if (sel < 10) d = gprev;
                else d = nxt(gcode, gprev);
                if (v) begin
                    gprev = d;
                    if (hold_left > 0) hold_left--;
                end
                model_step(rs, v, d);
                apply(rs, v, 8'(d));
                check_out($sformatf("rnd%0d", i), 4'(m_pat), m_lk, m_ps, m_wr, m_er);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
